b_dly_cal_ctrl: RTL and testbench

B_DLY_CAL_CTRL -- requirements
Module: b_dly_cal_ctrl

---
 rtl/b_dly_cal_ctrl_pkg.sv | 17 +
 rtl/b_dly_cal_ctrl_settle_cnt.sv | 26 ++
 rtl/b_dly_cal_ctrl.sv | 122 ++++++++++++
 tb/tb_b_dly_cal_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/b_dly_cal_ctrl_pkg.sv
// Shared constants for the delay-line calibration controller: code width,
// reset/saturation codes and FSM state encoding.
package b_dly_cal_ctrl_pkg;
   localparam int SEL_W = 9;
   localparam logic [SEL_W-1:0] CODE_RST = 9'h100;
   localparam logic [SEL_W-1:0] CODE_MIN = 9'd0;
   localparam logic [SEL_W-1:0] CODE_MAX = 9'd511;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_SAMPLE,
      ST_TRACK_WAIT,
      ST_TRACK_STEP
   } state_e;
endpackage

// File: rtl/b_dly_cal_ctrl_settle_cnt.sv
// Settle counter: counts P_SETTLE enabled cycles after a load and pulses
// o_done on the last one.
module b_dly_cal_ctrl_settle_cnt #(
   parameter int P_SETTLE = 8
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_load,
   input  logic i_en,
   output logic o_done
);
   localparam logic [7:0] TC = 8'(P_SETTLE - 1);

   logic [7:0] cnt_q;

   assign o_done = i_en && !i_load && (cnt_q == TC);

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn)
         cnt_q <= '0;
      else if (i_load)
         cnt_q <= '0;
      else if (i_en)
         cnt_q <= o_done ? '0 : cnt_q + 8'd1;
   end
endmodule

// File: rtl/b_dly_cal_ctrl.sv
// Delay-line calibration: 9-step SAR search on the phase detector, then
// optional +/-1 tracking with saturation flag.
module b_dly_cal_ctrl
   import b_dly_cal_ctrl_pkg::*;
#(
   parameter int P_SETTLE = 8,
   parameter int P_SEL_W  = SEL_W
) (
   input  logic               i_clk,
   input  logic               i_rstn,
   input  logic               i_start,
   input  logic               i_pd_late,
   input  logic               i_track_en,
   output logic [P_SEL_W-1:0] o_dly_sel,
   output logic               o_busy,
   output logic               o_lock,
   output logic               o_err
);
   localparam int PTR_W = $clog2(P_SEL_W);
   localparam logic [PTR_W-1:0] PTR_MSB = PTR_W'(P_SEL_W - 1);
   localparam logic [P_SEL_W-1:0] C_RST = P_SEL_W'(CODE_RST);
   localparam logic [P_SEL_W-1:0] C_MIN = P_SEL_W'(CODE_MIN);
   localparam logic [P_SEL_W-1:0] C_MAX = P_SEL_W'(CODE_MAX);

   state_e             state_q, state_d;
   logic [P_SEL_W-1:0] sel_q, sel_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               busy_q, busy_d, lock_q, lock_d, err_q, err_d;
   logic               counting, cnt_done;

   // The counter restarts whenever we leave a counting state or tracking pauses.
   assign counting = (state_q == ST_SETTLE) || (state_q == ST_TRACK_WAIT && i_track_en);

   b_dly_cal_ctrl_settle_cnt #(.P_SETTLE(P_SETTLE)) u_settle_cnt (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_load (i_start || !counting),
      .i_en   (counting && !i_start),
      .o_done (cnt_done)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= ST_IDLE;
         sel_q   <= C_RST;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
         lock_q  <= lock_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (i_start)
         state_d = ST_LOAD;
      else begin
         unique case (state_q)
            ST_IDLE:       state_d = ST_IDLE;
            ST_LOAD:       state_d = ST_SETTLE;
            ST_SETTLE:     if (cnt_done) state_d = ST_SAMPLE;
            ST_SAMPLE:     state_d = (ptr_q == '0) ? ST_TRACK_WAIT : ST_SETTLE;
            ST_TRACK_WAIT: if (cnt_done) state_d = ST_TRACK_STEP;
            ST_TRACK_STEP: state_d = ST_TRACK_WAIT;
            default:       state_d = ST_IDLE;
         endcase
      end
   end

   // A start pulse freezes the datapath for one cycle; LOAD then reinitialises it.
   always_comb begin
      sel_d  = sel_q;
      ptr_d  = ptr_q;
      busy_d = busy_q;
      lock_d = lock_q;
      err_d  = err_q;
      if (!i_start) begin
         unique case (state_q)
            ST_LOAD: begin
               sel_d  = C_RST;
               ptr_d  = PTR_MSB;
               busy_d = 1'b1;
               lock_d = 1'b0;
               err_d  = 1'b0;
            end
            ST_SAMPLE: begin
               if (i_pd_late)
                  sel_d[ptr_q] = 1'b0;
               if (ptr_q != '0) begin
                  sel_d[ptr_q - 1'b1] = 1'b1;
                  ptr_d = ptr_q - 1'b1;
               end else begin
                  busy_d = 1'b0;
                  lock_d = 1'b1;
               end
            end
            ST_TRACK_STEP: begin
               if (i_pd_late) begin
                  if (sel_q == C_MIN) err_d = 1'b1;
                  else                sel_d = sel_q - 1'b1;
               end else begin
                  if (sel_q == C_MAX) err_d = 1'b1;
                  else                sel_d = sel_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dly_sel = sel_q;
   assign o_busy    = busy_q;
   assign o_lock    = lock_q;
   assign o_err     = err_q;
endmodule

// File: tb/tb_b_dly_cal_ctrl.sv
// Bench for b_dly_cal_ctrl: timeline-based reference model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_b_dly_cal_ctrl;
   localparam int P   = 8;
   localparam int LAT = 1 + 9 * (P + 1);

   logic       clk = 1'b0, rstn = 1'b1, start = 1'b0, track_en = 1'b0;
   logic       pd_late;
   logic [8:0] dly_sel;
   logic       busy, lock, err;
   int         target = 300;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   // Delay model: too late whenever the selected delay exceeds the target.
   assign pd_late = (int'(dly_sel) > target);

   b_dly_cal_ctrl #(.P_SETTLE(P), .P_SEL_W(9)) dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_start    (start),
      .i_pd_late  (pd_late),
      .i_track_en (track_en),
      .o_dly_sel  (dly_sel),
      .o_busy     (busy),
      .o_lock     (lock),
      .o_err      (err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 searching (timed from the start edge), 2 tracking.
   int m_code = 256, m_mode = 0, m_t = 0, m_run = 0, m_b;
   bit m_busy = 0, m_lock = 0, m_err = 0, m_pend = 0;

   initial forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
         m_code = 256; m_busy = 0; m_lock = 0; m_err = 0; m_mode = 0;
      end else if (start) begin
         m_mode = 1; m_t = 0;
      end else if (m_mode == 1) begin
         m_t++;
         if (m_t == 1) begin
            m_code = 256; m_busy = 1; m_lock = 0; m_err = 0;
         end else if ((m_t - 1) % (P + 1) == 0) begin
            m_b = 9 - (m_t - 1) / (P + 1);
            if (m_code > target) m_code -= (1 << m_b);
            if (m_b > 0) m_code += (1 << (m_b - 1));
            else begin
               m_busy = 0; m_lock = 1; m_mode = 2; m_run = 0; m_pend = 0;
            end
         end
      end else if (m_mode == 2) begin
         if (m_pend) begin
            if (m_code > target) begin
               if (m_code == 0) m_err = 1; else m_code--;
            end else begin
               if (m_code == 511) m_err = 1; else m_code++;
            end
            m_pend = 0; m_run = 0;
         end else if (track_en) begin
            m_run++;
            if (m_run == P) m_pend = 1;
         end else
            m_run = 0;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("model_sel",  int'(dly_sel), m_code);
      chk("model_busy", int'(busy),    int'(m_busy));
      chk("model_lock", int'(lock),    int'(m_lock));
      chk("model_err",  int'(err),     int'(m_err));
   end

   // Leaves the bench at the falling edge right after the sampling edge.
   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int exp_trk[6];
      int tgt[2];
      int n;
      exp_trk = '{301, 302, 303, 304, 303, 304};
      tgt     = '{0, 511};

      #1 rstn = 1'b0;
      #3;
      chk("rst_sel", int'(dly_sel), 256);
      chk("rst_busy", int'(busy), 0);
      chk("rst_lock", int'(lock), 0);
      chk("rst_err", int'(err), 0);
      wait_cyc(1); @(negedge clk) rstn = 1'b1;
      wait_cyc(5);
      chk("idle_sel", int'(dly_sel), 256);
      chk("idle_busy", int'(busy), 0);

      // Basic lock at 300 with exact latency.
      target = 300; track_en = 1'b0;
      pulse_start();
      wait_cyc(1);
      chk("load_busy", int'(busy), 1);
      wait_cyc(LAT - 2);
      chk("lat_pre_lock", int'(lock), 0);
      wait_cyc(1);
      chk("lat_lock", int'(lock), 1);
      chk("lat_sel", int'(dly_sel), 300);
      chk("lat_busy", int'(busy), 0);

      // Code range extremes.
      foreach (tgt[i]) begin
         target = tgt[i];
         pulse_start(); wait_cyc(LAT);
         chk("edge_sel", int'(dly_sel), tgt[i]);
         chk("edge_err", int'(err), 0);
         chk("edge_lock", int'(lock), 1);
      end

      // Tracking towards a moved target, then dither.
      target = 300; track_en = 1'b1;
      pulse_start(); wait_cyc(LAT);
      chk("trk_lock_sel", int'(dly_sel), 300);
      target = 303;
      foreach (exp_trk[i]) begin
         wait_cyc(P + 1);
         chk("trk_step_sel", int'(dly_sel), exp_trk[i]);
         chk("trk_lock", int'(lock), 1);
      end

      // Saturation at the top of the range.
      target = 511; track_en = 1'b1;
      pulse_start(); wait_cyc(LAT);
      chk("sat_sel0", int'(dly_sel), 511);
      wait_cyc(P);
      chk("sat_err_pre", int'(err), 0);
      wait_cyc(1);
      chk("sat_err", int'(err), 1);
      chk("sat_sel", int'(dly_sel), 511);
      chk("sat_lock", int'(lock), 1);
      pulse_start(); wait_cyc(1);
      chk("sat_clr_err", int'(err), 0);
      chk("sat_clr_sel", int'(dly_sel), 256);
      chk("sat_clr_lock", int'(lock), 0);

      // Restart on the 40th cycle of a search.
      target = 123; track_en = 1'b0;
      pulse_start(); wait_cyc(39);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_cyc(1);
      chk("abort_sel", int'(dly_sel), 256);
      chk("abort_busy", int'(busy), 1);
      chk("abort_lock", int'(lock), 0);
      wait_cyc(LAT - 2);
      chk("abort_pre_lock", int'(lock), 0);
      wait_cyc(1);
      chk("abort_lock2", int'(lock), 1);
      chk("abort_final", int'(dly_sel), 123);

      // Reset in the middle of a search.
      target = 77;
      pulse_start(); wait_cyc(30);
      #2 rstn = 1'b0;
      #1;
      chk("mrst_sel", int'(dly_sel), 256);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_lock", int'(lock), 0);
      chk("mrst_err", int'(err), 0);
      @(negedge clk) rstn = 1'b1;
      wait_cyc(20);
      chk("mrst_idle_sel", int'(dly_sel), 256);
      chk("mrst_idle_busy", int'(busy), 0);
      chk("mrst_idle_lock", int'(lock), 0);

      // Random traffic, checked by the model every cycle.
      for (int it = 0; it < 10; it++) begin
         target   = $urandom_range(0, 511);
         track_en = 1'($urandom_range(0, 1));
         pulse_start();
         n = $urandom_range(60, 300);
         for (int c = 0; c < n; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 15) == 0) track_en = ~track_en;
            if ($urandom_range(0, 31) == 0) target = $urandom_range(0, 511);
         end
         @(negedge clk) start = 1'b0;
      end
      wait_cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
